// File: rtl/card_pkg.sv
// Shared constants, FSM state type and index-to-card mapping for the card shoe.
// The mapping uses a compare chain instead of a divider.
package card_pkg;

    localparam int         DECK_SIZE     = 52;
    localparam int         NUM_RANKS     = 13;
    localparam logic [5:0] FULL_COUNT    = 6'd52;

    // Feedback taps for x^6 + x^5 + 1 (bits 5 and 4 of the shift register).
    localparam logic [5:0] LFSR_TAPS     = 6'b110000;
    localparam logic [5:0] LFSR_ZERO_FIX = 6'h01;

    typedef enum logic {IDLE, SEARCH} state_t;

    typedef struct packed {
        logic [4:0] rank;
        logic [1:0] suit;
    } card_t;

    function automatic card_t index_to_card(input logic [5:0] index);
        card_t      card;
        logic [4:0] offset;
        if (index < 6'(NUM_RANKS)) begin
            card.suit = 2'd0;
            offset    = index[4:0];
        end else if (index < 6'(2 * NUM_RANKS)) begin
            card.suit = 2'd1;
            offset    = 5'(index - 6'(NUM_RANKS));
        end else if (index < 6'(3 * NUM_RANKS)) begin
            card.suit = 2'd2;
            offset    = 5'(index - 6'(2 * NUM_RANKS));
        end else begin
            card.suit = 2'd3;
            offset    = 5'(index - 6'(3 * NUM_RANKS));
        end
        card.rank = offset + 5'd1;
        return card;
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// Synchronizes a raw active-low key and emits a one-cycle registered strobe
// on its falling edge; holding the key low yields exactly one strobe.
module key_press_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clock,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // NOTE: every register here uses <= so all stages sample the pre-edge
    // values; blocking assignments would collapse the chain into one stage.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '1;
            prev  <= 1'b1;
            press <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], key_n};
            prev  <= sync[SYNC_STAGES-1];
            press <= prev & ~sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/card_shoe.sv
// Deals cards without replacement from a 52-card deck using a free-running LFSR
// as the candidate source; shuffle clears the dealt mask and restores the count.
module card_shoe
    import card_pkg::*;
#(
    parameter logic [5:0] LFSR_SEED   = 6'h2B,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Clock,
    input  logic       reset_n,
    input  logic       draw_n,
    input  logic       shuffle_n,
    output logic [4:0] card_rank,
    output logic [1:0] card_suit,
    output logic       card_valid,
    output logic       busy,
    output logic [5:0] cards_left,
    output logic       deck_empty
);

    localparam logic [5:0] SEED = (LFSR_SEED == 6'd0) ? LFSR_ZERO_FIX : LFSR_SEED;

    logic        draw_stb;
    logic        shuffle_stb;
    logic [5:0]  lfsr;
    logic [5:0]  cand_idx;
    logic        cand_ok;
    card_t       cand_card;
    logic [63:0] used;
    state_t      state;

    key_press_detect #(.SYNC_STAGES(SYNC_STAGES)) u_draw_key (
        .Clock   (Clock),
        .reset_n (reset_n),
        .key_n   (draw_n),
        .press   (draw_stb)
    );

    key_press_detect #(.SYNC_STAGES(SYNC_STAGES)) u_shuffle_key (
        .Clock   (Clock),
        .reset_n (reset_n),
        .key_n   (shuffle_n),
        .press   (shuffle_stb)
    );

    // The mask spans all 64 LFSR-addressable indices; bits 52..63 are never set.
    assign cand_idx   = lfsr - 6'd1;
    assign cand_ok    = (cand_idx < 6'(DECK_SIZE)) && !used[cand_idx];
    assign cand_card  = index_to_card(cand_idx);
    assign deck_empty = (cards_left == 6'd0);

    // NOTE: the dealt mask is plain flops, not a RAM, so it is cleared by reset
    // and by shuffle in a single cycle.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr       <= SEED;
            used       <= '0;
            cards_left <= FULL_COUNT;
            card_rank  <= 5'd0;
            card_suit  <= 2'd0;
            card_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
        end else begin
            lfsr       <= {lfsr[4:0], ^(lfsr & LFSR_TAPS)};
            card_valid <= 1'b0;
            if (shuffle_stb) begin
                used       <= '0;
                cards_left <= FULL_COUNT;
                busy       <= 1'b0;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (draw_stb && !deck_empty) begin
                            busy  <= 1'b1;
                            state <= SEARCH;
                        end
                    end
                    SEARCH: begin
                        if (cand_ok) begin
                            card_rank      <= cand_card.rank;
                            card_suit      <= cand_card.suit;
                            used[cand_idx] <= 1'b1;
                            cards_left     <= cards_left - 6'd1;
                            card_valid     <= 1'b1;
                            busy           <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: table-driven key sequences plus directed
// multi-cycle cases, with an LFSR reference model predicting each dealt card.
module tb_card_shoe;

    localparam logic [5:0] SEED = 6'h2B;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       draw_n = 1'b1;
    logic       shuffle_n = 1'b1;
    logic [4:0] card_rank;
    logic [1:0] card_suit;
    logic       card_valid;
    logic       busy;
    logic [5:0] cards_left;
    logic       deck_empty;

    card_shoe #(.LFSR_SEED(SEED), .SYNC_STAGES(2)) dut (
        .Clock      (clk),
        .reset_n    (rst_n),
        .draw_n     (draw_n),
        .shuffle_n  (shuffle_n),
        .card_rank  (card_rank),
        .card_suit  (card_suit),
        .card_valid (card_valid),
        .busy       (busy),
        .cards_left (cards_left),
        .deck_empty (deck_empty)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference LFSR; m_prev is the candidate value tested on the previous cycle.
    logic [5:0] m_lfsr;
    logic [5:0] m_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
        end
    end

    // Monitor: logs every dealt card next to the model's prediction.
    int valid_count = 0;
    int got_rank [256];
    int got_suit [256];
    int exp_rank [256];
    int exp_suit [256];
    int mon_idx;
    always @(negedge clk) begin
        if (rst_n && card_valid === 1'b1 && valid_count < 256) begin
            mon_idx = int'(m_prev) - 1;
            got_rank[valid_count] = int'(card_rank);
            got_suit[valid_count] = int'(card_suit);
            if (mon_idx >= 0 && mon_idx < 52) begin
                exp_rank[valid_count] = (mon_idx % 13) + 1;
                exp_suit[valid_count] = mon_idx / 13;
            end else begin
                exp_rank[valid_count] = -1;
                exp_suit[valid_count] = -1;
            end
            valid_count++;
        end
    end

    int checked = 0;
    int gen = 1;
    int seen_gen [52];

    task automatic verify_cards();
        int idx;
        while (checked < valid_count) begin
            check($sformatf("card%0d_rank", checked), got_rank[checked], exp_rank[checked]);
            check($sformatf("card%0d_suit", checked), got_suit[checked], exp_suit[checked]);
            idx = got_suit[checked] * 13 + got_rank[checked] - 1;
            check($sformatf("card%0d_in_deck", checked),
                  (got_rank[checked] >= 1 && got_rank[checked] <= 13) ? 1 : 0, 1);
            if (idx >= 0 && idx < 52) begin
                check($sformatf("card%0d_distinct", checked), (seen_gen[idx] == gen) ? 1 : 0, 0);
                seen_gen[idx] = gen;
            end
            checked++;
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rank"}, int'(card_rank), 0);
        check({tag, "_suit"}, int'(card_suit), 0);
        check({tag, "_valid"}, int'(card_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_left"}, int'(cards_left), 52);
        check({tag, "_empty"}, int'(deck_empty), 0);
    endtask

    task automatic do_reset();
        verify_cards();
        rst_n     = 1'b0;
        draw_n    = 1'b1;
        shuffle_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst_n = 1'b1;
        gen++;
    endtask

    task automatic do_draw(input int hold);
        int v0;
        int n;
        v0 = valid_count;
        n  = 0;
        draw_n = 1'b0;
        while (valid_count == v0 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == hold) draw_n = 1'b1;
        end
        draw_n = 1'b1;
        check("draw_one_valid", valid_count - v0, 1);
        repeat (5) @(negedge clk);
        check("draw_single_pulse", valid_count - v0, 1);
        verify_cards();
    endtask

    typedef enum int {OP_IDLE, OP_DRAW, OP_SHUF, OP_BOTH} op_e;
    typedef struct {
        op_e op;
        int  hold;
        int  exp_valids;
        int  exp_left;
        int  exp_empty;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int n;
        int busy_max;
        int held_rank;
        int held_suit;

        vecs[0] = '{OP_IDLE, 100, 0, 52, 0};
        vecs[1] = '{OP_DRAW,  20, 1, 51, 0};
        vecs[2] = '{OP_DRAW,   1, 1, 50, 0};
        vecs[3] = '{OP_SHUF,   5, 0, 52, 0};
        vecs[4] = '{OP_BOTH,   3, 0, 52, 0};
        vecs[5] = '{OP_DRAW,   2, 1, 51, 0};
        vecs[6] = '{OP_IDLE,  50, 0, 51, 0};

        // Reset state, idle, single draws, shuffle, simultaneous keys.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            v0 = valid_count;
            if (vecs[i].op == OP_SHUF || vecs[i].op == OP_BOTH) gen++;
            draw_n    = !(vecs[i].op == OP_DRAW || vecs[i].op == OP_BOTH);
            shuffle_n = !(vecs[i].op == OP_SHUF || vecs[i].op == OP_BOTH);
            repeat (vecs[i].hold) @(negedge clk);
            draw_n    = 1'b1;
            shuffle_n = 1'b1;
            repeat (100) @(negedge clk);
            check($sformatf("vec%0d_valids", i), valid_count - v0, vecs[i].exp_valids);
            check($sformatf("vec%0d_left", i), int'(cards_left), vecs[i].exp_left);
            check($sformatf("vec%0d_empty", i), int'(deck_empty), vecs[i].exp_empty);
            check($sformatf("vec%0d_busy", i), int'(busy), 0);
            verify_cards();
        end

        // Full deck, then a draw on an empty deck.
        do_reset();
        for (int i = 0; i < 52; i++) do_draw(3);
        check("full_left", int'(cards_left), 0);
        check("full_empty", int'(deck_empty), 1);
        v0 = valid_count;
        busy_max = 0;
        draw_n = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_max = 1;
            if (i == 20) draw_n = 1'b1;
        end
        check("empty_draw_busy", busy_max, 0);
        check("empty_draw_valids", valid_count - v0, 0);
        check("empty_draw_left", int'(cards_left), 0);

        // Shuffle after partial deal holds the last card, then a full deal.
        do_reset();
        for (int i = 0; i < 10; i++) do_draw(3);
        held_rank = exp_rank[valid_count - 1];
        held_suit = exp_suit[valid_count - 1];
        gen++;
        shuffle_n = 1'b0;
        repeat (3) @(negedge clk);
        shuffle_n = 1'b1;
        repeat (10) @(negedge clk);
        check("shuf_left", int'(cards_left), 52);
        check("shuf_rank_held", int'(card_rank), held_rank);
        check("shuf_suit_held", int'(card_suit), held_suit);
        check("shuf_empty", int'(deck_empty), 0);
        for (int i = 0; i < 52; i++) do_draw(2);
        check("redeal_left", int'(cards_left), 0);
        check("redeal_empty", int'(deck_empty), 1);

        // Shuffle strobe landing on the first SEARCH cycle cancels the draw.
        do_reset();
        for (int i = 0; i < 3; i++) do_draw(3);
        v0 = valid_count;
        draw_n = 1'b0;
        @(negedge clk);
        shuffle_n = 1'b0;
        gen++;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("search_busy_seen", int'(busy), 1);
        @(negedge clk);
        check("search_shuf_busy", int'(busy), 0);
        check("search_shuf_valid", int'(card_valid), 0);
        draw_n    = 1'b1;
        shuffle_n = 1'b1;
        repeat (100) @(negedge clk);
        check("search_shuf_valids", valid_count - v0, 0);
        check("search_shuf_left", int'(cards_left), 52);

        // Asynchronous reset in the middle of a SEARCH.
        do_reset();
        do_draw(3);
        draw_n = 1'b0;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("async_busy_seen", int'(busy), 1);
        #2;
        rst_n  = 1'b0;
        draw_n = 1'b1;
        #1;
        reset_checks("async");
        @(negedge clk);
        rst_n = 1'b1;
        gen++;
        do_draw(3);
        check("async_after_left", int'(cards_left), 51);

        verify_cards();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
